// File: rtl/cordic_chan_sched.sv
// Pipelined 24-bit-phase CORDIC rotator shared round-robin between NCH
// channels. Each channel has its own NCO accumulator. A tag pipeline that
// matches the CORDIC latency returns each result with its channel index.

module m_cordic_z24 #(
  parameter int BW  = 16,
  parameter int NST = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [BW-1:0] xi,
  input  logic [BW-1:0] yi,
  input  logic [23:0]   zi,
  input  logic          flag_in,
  output logic [BW-1:0] xo,
  output logic [BW-1:0] yo,
  output logic [23:0]   zo,
  output logic          flag_out
);
  // Two guard bits below the LSB and two headroom bits above the MSB.
  localparam int IW = BW + 4;

  logic signed [IW-1:0] r_x [NST+1];
  logic signed [IW-1:0] r_y [NST+1];
  logic signed [23:0]   r_z [NST+1];
  logic                 r_f [NST+1];
  logic                 w_fold;
  logic signed [IW-1:0] w_xe;
  logic signed [IW-1:0] w_ye;
  logic                 w_unused;

  // atan(2^-i) with full circle = 2^24, rounded from a 2^32 table.
  function automatic logic signed [23:0] atan24(input int unsigned i);
    logic [31:0] a;
    case (i)
      0:  a = 32'h2000_0000;  1:  a = 32'h12E4_051E;
      2:  a = 32'h09FB_385B;  3:  a = 32'h0511_11D4;
      4:  a = 32'h028B_0D43;  5:  a = 32'h0145_D7E1;
      6:  a = 32'h00A2_F61E;  7:  a = 32'h0051_7C55;
      8:  a = 32'h0028_BE53;  9:  a = 32'h0014_5F2F;
      10: a = 32'h000A_2F98;  11: a = 32'h0005_17CC;
      12: a = 32'h0002_8BE6;  13: a = 32'h0001_45F3;
      14: a = 32'h0000_A2FA;  15: a = 32'h0000_517D;
      16: a = 32'h0000_28BE;  17: a = 32'h0000_145F;
      18: a = 32'h0000_0A30;  19: a = 32'h0000_0518;
      default: a = '0;
    endcase
    return 24'((a + 32'd128) >> 8);
  endfunction

  // Angles in [90,270) deg are pre-rotated by 180 so micro-rotations converge.
  assign w_fold = zi[23] ^ zi[22];
  assign w_xe   = {{2{xi[BW-1]}}, xi, 2'b00};
  assign w_ye   = {{2{yi[BW-1]}}, yi, 2'b00};

  // Input register with quadrant fold, then NST shift-add micro-rotation stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NST; i++) r_f[i] <= 1'b0;
    end else if (en) begin
      r_f[0] <= flag_in;
      r_x[0] <= w_fold ? -w_xe : w_xe;
      r_y[0] <= w_fold ? -w_ye : w_ye;
      r_z[0] <= w_fold ? zi + 24'h80_0000 : zi;
      for (int unsigned i = 0; i < NST; i++) begin
        r_f[i+1] <= r_f[i];
        if (!r_z[i][23]) begin
          r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] - atan24(i);
        end else begin
          r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] + atan24(i);
        end
      end
    end
  end

  assign xo       = r_x[NST][BW+1:2];
  assign yo       = r_y[NST][BW+1:2];
  assign zo       = r_z[NST];
  assign flag_out = r_f[NST];
  assign w_unused = ^{r_x[NST][IW-1:BW+2], r_x[NST][1:0], r_y[NST][IW-1:BW+2], r_y[NST][1:0]};
endmodule

module cordic_chan_sched #(
  parameter int NCH = 4,
  parameter int BW  = 16,
  parameter int LAT = 21
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_chan,
  input  logic [23:0]              cfg_phase_inc,
  input  logic                     cfg_phase_clr,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  input  logic [NCH*BW-1:0]        in_x,
  input  logic [NCH*BW-1:0]        in_y,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_chan,
  output logic [BW-1:0]            out_x,
  output logic [BW-1:0]            out_y,
  output logic [23:0]              out_phase
);
  localparam int CHW = $clog2(NCH);

  logic [23:0]    r_acc [NCH];
  logic [23:0]    r_inc [NCH];
  logic [CHW-1:0] r_rr;
  logic           r_tv [LAT];
  logic [CHW-1:0] r_tc [LAT];
  logic           w_gvalid;
  logic [CHW-1:0] w_gidx;
  logic [CHW-1:0] w_rr_nxt;
  logic [BW-1:0]  w_xi;
  logic [BW-1:0]  w_yi;
  logic [23:0]    w_zi;
  logic           w_cflag;

  // Round-robin arbiter: first requester at or after the rr pointer.
  always_comb begin
    logic [CHW-1:0] idx;
    w_gvalid = 1'b0;
    w_gidx   = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = CHW'((32'(r_rr) + k) % NCH);
      if (!w_gvalid && in_valid[idx]) begin
        w_gvalid = 1'b1;
        w_gidx   = idx;
      end
    end
    if (!enable || reset) w_gvalid = 1'b0;
  end

  // Grant decode and CORDIC input mux; idle cycles feed zeros.
  always_comb begin
    in_ready = '0;
    w_xi     = '0;
    w_yi     = '0;
    w_zi     = '0;
    w_rr_nxt = CHW'((32'(w_gidx) + 1) % NCH);
    if (w_gvalid) begin
      in_ready[w_gidx] = 1'b1;
      w_xi = in_x[w_gidx*BW +: BW];
      w_yi = in_y[w_gidx*BW +: BW];
      w_zi = r_acc[w_gidx];
    end
  end

  // NCO accumulators, increments and rr pointer; a clear overrides the accumulate.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        r_acc[k] <= '0;
        r_inc[k] <= '0;
      end
      r_rr <= '0;
    end else begin
      if (w_gvalid) begin
        r_acc[w_gidx] <= r_acc[w_gidx] + r_inc[w_gidx];
        r_rr          <= w_rr_nxt;
      end
      if (cfg_we) begin
        r_inc[cfg_chan] <= cfg_phase_inc;
        if (cfg_phase_clr) r_acc[cfg_chan] <= '0;
      end
    end
  end

  // Tag pipeline {valid, chan} aligned with the CORDIC latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_tv[i] <= 1'b0;
        r_tc[i] <= '0;
      end
    end else begin
      r_tv[0] <= w_gvalid;
      r_tc[0] <= w_gidx;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tc[i] <= r_tc[i-1];
      end
    end
  end

  // CORDIC flag and tag valid must always agree.
  always_ff @(posedge clock) begin
    if (!reset) assert (w_cflag == r_tv[LAT-1]);
  end

  m_cordic_z24 #(.BW(BW), .NST(LAT-1)) u_cordic (
    .clk      (clock),
    .rst      (reset),
    .en       (1'b1),
    .xi       (w_xi),
    .yi       (w_yi),
    .zi       (w_zi),
    .flag_in  (w_gvalid),
    .xo       (out_x),
    .yo       (out_y),
    .zo       (out_phase),
    .flag_out (w_cflag)
  );

  assign out_valid = w_cflag & r_tv[LAT-1];
  assign out_chan  = r_tc[LAT-1];
endmodule

// File: tb/tb_cordic_chan_sched.sv
// Bench for cordic_chan_sched: randomized stimulus against a queue-based
// behavioural model using real-valued rotation.

module tb_cordic_chan_sched;
  localparam int  NCH = 4;
  localparam int  BW  = 16;
  localparam int  LAT = 21;
  localparam int  CHW = 2;
  localparam real KG  = 1.6467602581210654;
  localparam real TWO_PI = 6.283185307179586;
  localparam real TOL = 4.0;

  logic              clock, reset, enable, cfg_we, cfg_phase_clr;
  logic [CHW-1:0]    cfg_chan;
  logic [23:0]       cfg_phase_inc;
  logic [NCH-1:0]    in_valid, in_ready;
  logic [NCH*BW-1:0] in_x, in_y;
  logic              out_valid;
  logic [CHW-1:0]    out_chan;
  logic [BW-1:0]     out_x, out_y;
  logic [23:0]       out_phase;

  cordic_chan_sched #(.NCH(NCH), .BW(BW), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_phase_inc(cfg_phase_inc), .cfg_phase_clr(cfg_phase_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_chan(out_chan), .out_x(out_x), .out_y(out_y),
    .out_phase(out_phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int due; int ch; int x; int y; int ph; } exp_t;
  exp_t q[$];
  int m_acc[NCH];
  int m_inc[NCH];
  int m_rr;
  int cyc, tcyc, n_chk, n_pass;
  logic [NCH-1:0] exp_rdy, obs_rdy;
  logic exp_ov, obs_ov;
  int   exp_oc, obs_oc, obs_ox, obs_oy, obs_zo;
  real  exp_ox, exp_oy;

  task automatic set_data(input int c, input int x, input int y);
    in_x[c*BW +: BW] = BW'(x);
    in_y[c*BW +: BW] = BW'(y);
  endtask

  task automatic rand_data();
    for (int c = 0; c < NCH; c++)
      set_data(c, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
  endtask

  task automatic cfg(input int c, input int inc, input logic clr);
    cfg_we = 1'b1; cfg_chan = CHW'(c); cfg_phase_inc = 24'(inc); cfg_phase_clr = clr;
  endtask

  task automatic cfg_off();
    cfg_we = 1'b0; cfg_phase_clr = 1'b0;
  endtask

  // One clock: model prediction, capture of DUT outputs at negedge, model update.
  task automatic tick();
    int   g;
    real  ang;
    exp_t e;
    @(negedge clock);
    tcyc = cyc;
    g = -1;
    if (!reset && enable)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && in_valid[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_ov = 1'b0; exp_oc = 0; exp_ox = 0.0; exp_oy = 0.0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ang = real'(e.ph) * TWO_PI / 16777216.0;
      exp_ov = 1'b1;
      exp_oc = e.ch;
      exp_ox = KG * (real'(e.x) * $cos(ang) - real'(e.y) * $sin(ang));
      exp_oy = KG * (real'(e.x) * $sin(ang) + real'(e.y) * $cos(ang));
    end
    obs_rdy = in_ready; obs_ov = out_valid; obs_oc = int'(out_chan);
    obs_ox = int'($signed(out_x)); obs_oy = int'($signed(out_y)); obs_zo = int'($signed(out_phase));
    if (reset) begin
      q.delete();
      m_rr = 0;
      for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_inc[c] = 0; end
    end else begin
      if (g >= 0) begin
        e.due = cyc + LAT; e.ch = g; e.ph = m_acc[g];
        e.x = int'($signed(in_x[g*BW +: BW]));
        e.y = int'($signed(in_y[g*BW +: BW]));
        q.push_back(e);
        m_acc[g] = (m_acc[g] + m_inc[g]) & 32'hFF_FFFF;
        m_rr = (g + 1) % NCH;
      end
      if (cfg_we) begin
        m_inc[cfg_chan] = int'(cfg_phase_inc);
        if (cfg_phase_clr) m_acc[cfg_chan] = 0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; in_valid = '1; rand_data();
    for (int n = 0; n < 3; n++) begin
      tick();
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL reset_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== 1'b0) $display("FAIL reset_valid cyc=%0d got=%b exp=0", tcyc, obs_ov); else n_pass++;
    end
    reset = 1'b0; in_valid = '0;
    tick();
    n_chk++; if (obs_ov !== 1'b0) $display("FAIL reset_valid_after cyc=%0d got=%b exp=0", tcyc, obs_ov); else n_pass++;
    n_chk++; if (obs_oc !== 0) $display("FAIL reset_chan cyc=%0d got=%0d exp=0", tcyc, obs_oc); else n_pass++;
  endtask

  task automatic test_rotate();
    int first_g, first_o;
    real dx, dy;
    first_g = -1; first_o = -1;
    cfg(0, 24'h40_0000, 1'b0); tick(); cfg_off();
    for (int c = 0; c < NCH; c++) set_data(c, 16'h4000, 0);
    for (int n = 0; n < 12 + LAT + 3; n++) begin
      in_valid = (n < 12) ? 4'b0001 : 4'b0000;
      tick();
      if (obs_rdy[0] && first_g < 0) first_g = tcyc;
      if (obs_ov && first_o < 0) first_o = tcyc;
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL rot_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL rot_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        dx = $itor(obs_ox) - exp_ox; if (dx < 0.0) dx = -dx;
        dy = $itor(obs_oy) - exp_oy; if (dy < 0.0) dy = -dy;
        n_chk++; if (obs_oc !== 0) $display("FAIL rot_chan cyc=%0d got=%0d exp=0", tcyc, obs_oc); else n_pass++;
        n_chk++; if (dx > TOL || dy > TOL) $display("FAIL rot_xy cyc=%0d got=(%0d,%0d) exp=(%0.1f,%0.1f)", tcyc, obs_ox, obs_oy, exp_ox, exp_oy); else n_pass++;
      end
    end
    n_chk++; if (first_o - first_g !== LAT) $display("FAIL rot_latency got=%0d exp=%0d", first_o - first_g, LAT); else n_pass++;
  endtask

  task automatic test_all_valid();
    real dx, dy;
    for (int c = 0; c < NCH; c++) begin cfg(c, int'($urandom_range(0, 24'hFF_FFFF)), 1'b0); tick(); end
    cfg_off();
    for (int n = 0; n < 40 + LAT + 2; n++) begin
      in_valid = (n < 40) ? 4'b1111 : 4'b0000;
      rand_data();
      tick();
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL all_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      if (n < 40) begin
        n_chk++; if (!$onehot(obs_rdy)) $display("FAIL all_onehot cyc=%0d got=%b", tcyc, obs_rdy); else n_pass++;
      end
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL all_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        dx = $itor(obs_ox) - exp_ox; if (dx < 0.0) dx = -dx;
        dy = $itor(obs_oy) - exp_oy; if (dy < 0.0) dy = -dy;
        n_chk++; if (obs_oc !== exp_oc) $display("FAIL all_chan cyc=%0d got=%0d exp=%0d", tcyc, obs_oc, exp_oc); else n_pass++;
        n_chk++; if (dx > TOL || dy > TOL) $display("FAIL all_xy cyc=%0d got=(%0d,%0d) exp=(%0.1f,%0.1f)", tcyc, obs_ox, obs_oy, exp_ox, exp_oy); else n_pass++;
      end
    end
  endtask

  task automatic test_sparse();
    for (int n = 0; n < 18 + LAT + 2; n++) begin
      in_valid = (n < 10) ? 4'b1010 : (n < 18) ? 4'b0010 : 4'b0000;
      rand_data();
      tick();
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL sparse_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL sparse_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        n_chk++; if (obs_oc !== exp_oc) $display("FAIL sparse_chan cyc=%0d got=%0d exp=%0d", tcyc, obs_oc, exp_oc); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    real dx, dy;
    reset = 1'b1; in_valid = '0; tick(); reset = 1'b0;
    cfg(2, 24'h7F_FFFF, 1'b0); tick(); cfg_off();
    for (int n = 0; n < 4 + LAT + 2; n++) begin
      in_valid = (n < 4) ? 4'b0100 : 4'b0000;
      rand_data();
      tick();
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        dx = $itor(obs_ox) - exp_ox; if (dx < 0.0) dx = -dx;
        dy = $itor(obs_oy) - exp_oy; if (dy < 0.0) dy = -dy;
        n_chk++; if (obs_oc !== 2) $display("FAIL wrap_chan cyc=%0d got=%0d exp=2", tcyc, obs_oc); else n_pass++;
        n_chk++; if (dx > TOL || dy > TOL) $display("FAIL wrap_xy cyc=%0d got=(%0d,%0d) exp=(%0.1f,%0.1f)", tcyc, obs_ox, obs_oy, exp_ox, exp_oy); else n_pass++;
        n_chk++; if (obs_zo > 64 || obs_zo < -64) $display("FAIL wrap_residual cyc=%0d got=%0d exp=|z|<=64", tcyc, obs_zo); else n_pass++;
      end
    end
  endtask

  task automatic test_cfg_clr();
    real dx, dy;
    cfg(0, 24'h12_3456, 1'b0); tick(); cfg_off();
    for (int n = 0; n < 7 + LAT + 2; n++) begin
      in_valid = (n < 7) ? 4'b0001 : 4'b0000;
      if (n == 3) cfg(0, 24'h20_0000, 1'b1); else cfg_off();
      rand_data();
      tick();
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL clr_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL clr_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        dx = $itor(obs_ox) - exp_ox; if (dx < 0.0) dx = -dx;
        dy = $itor(obs_oy) - exp_oy; if (dy < 0.0) dy = -dy;
        n_chk++; if (dx > TOL || dy > TOL) $display("FAIL clr_xy cyc=%0d got=(%0d,%0d) exp=(%0.1f,%0.1f)", tcyc, obs_ox, obs_oy, exp_ox, exp_oy); else n_pass++;
      end
    end
    cfg_off();
  endtask

  task automatic test_random();
    real dx, dy;
    for (int n = 0; n < 150 + LAT + 2; n++) begin
      enable   = (n < 150) ? ($urandom_range(0, 7) != 0) : 1'b1;
      in_valid = (n < 150) ? NCH'($urandom) : '0;
      if (n < 150 && $urandom_range(0, 5) == 0)
        cfg(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 24'hFF_FFFF)), $urandom_range(0, 3) == 0);
      else cfg_off();
      rand_data();
      tick();
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
      if (exp_ov && obs_ov) begin
        dx = $itor(obs_ox) - exp_ox; if (dx < 0.0) dx = -dx;
        dy = $itor(obs_oy) - exp_oy; if (dy < 0.0) dy = -dy;
        n_chk++; if (obs_oc !== exp_oc) $display("FAIL rand_chan cyc=%0d got=%0d exp=%0d", tcyc, obs_oc, exp_oc); else n_pass++;
        n_chk++; if (dx > TOL || dy > TOL) $display("FAIL rand_xy cyc=%0d got=(%0d,%0d) exp=(%0.1f,%0.1f)", tcyc, obs_ox, obs_oy, exp_ox, exp_oy); else n_pass++;
      end
    end
    cfg_off();
  endtask

  task automatic test_enable_reset();
    int n_out;
    n_out = 0;
    in_valid = '1;
    for (int n = 0; n < 5 + LAT + 4; n++) begin
      enable = (n < 5);
      rand_data();
      tick();
      if (obs_ov) n_out++;
      n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL en_ready cyc=%0d got=%b exp=%b", tcyc, obs_rdy, exp_rdy); else n_pass++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL en_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
    end
    n_chk++; if (n_out !== 5) $display("FAIL en_drain_count got=%0d exp=5", n_out); else n_pass++;
    enable = 1'b1;
    for (int n = 0; n < 8; n++) begin rand_data(); tick(); end
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b0; in_valid = '0;
    n_out = 0;
    for (int n = 0; n < LAT + 2; n++) begin
      tick();
      if (obs_ov) n_out++;
      n_chk++; if (obs_ov !== exp_ov) $display("FAIL rst_flush_valid cyc=%0d got=%b exp=%b", tcyc, obs_ov, exp_ov); else n_pass++;
    end
    n_chk++; if (n_out !== 0) $display("FAIL rst_flush_count got=%0d exp=0", n_out); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; m_rr = 0;
    for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_inc[c] = 0; end
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_phase_clr = 1'b0;
    cfg_chan = '0; cfg_phase_inc = '0; in_valid = '0; in_x = '0; in_y = '0;
    test_reset();
    test_rotate();
    test_all_valid();
    test_sparse();
    test_wrap();
    test_cfg_clr();
    test_random();
    test_enable_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
